// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard for the decode stage.
//
// Tracks every general-register write between issue (ID->EX handshake)
// and write-back (WS->RF write). Decode may hand off only when:
//   - none of its source registers has a pending write, and
//   - its own destination can still be tracked.
// No forwarding is done, so a reader waits until every pending write to
// its source has landed in the register file.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ds_valid          decode holds a valid instruction
//   ds_rj/ds_use_rj   source 1 address / used
//   ds_r2/ds_use_r2   source 2 address / used
//   ds_dest/ds_gr_we  destination address / writes a GR
//   ds_issue          decode->execute handshake this cycle
//   ws_we/ws_waddr    write-back register write
//   sb_clear          flush: drop every tracked write
//   ds_ready_go       decode may hand off (combinational)
//   sb_inflight       total tracked writes in flight
//   sb_err            sticky protocol-violation flag
//
// Optional build macro SB_STATS_EN adds two saturating 32-bit counters:
//   sb_stall_cycles   cycles with ds_valid && !ds_ready_go
//   sb_full_cycles    cycles where lack of tracking capacity stalled decode
// Only reset clears them; sb_clear does not.

// Per-register pending-write counter.
module sb_cnt_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // inc and dec together cancel out; the caller never raises inc at
  // saturation or dec at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)            cnt_d = '0;
    else if (inc && !dec) cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module reg_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int TOT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds_valid,
  input  logic [4:0]       ds_rj,
  input  logic             ds_use_rj,
  input  logic [4:0]       ds_r2,
  input  logic             ds_use_r2,
  input  logic [4:0]       ds_dest,
  input  logic             ds_gr_we,
  input  logic             ds_issue,
  input  logic             ws_we,
  input  logic [4:0]       ws_waddr,
  input  logic             sb_clear,
  output logic             ds_ready_go,
  output logic [TOT_W-1:0] sb_inflight,
  output logic             sb_err
`ifdef SB_STATS_EN
  ,
  output logic [31:0]      sb_stall_cycles,
  output logic [31:0]      sb_full_cycles
`endif
);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_INFLIGHT);

  logic [31:0][CNT_W-1:0] cnt;
  logic [31:0]            inc_vec, dec_vec;
  logic [TOT_W-1:0]       tot_q, tot_d;
  logic                   err_q, err_d;

  logic src_hit, track, full, ready_go;
  logic issue_bad, do_inc;
  logic ret_req, ret_under, do_dec;

  // r0 is hard-wired zero and never tracked.
  assign cnt[0]     = '0;
  assign inc_vec[0] = 1'b0;
  assign dec_vec[0] = 1'b0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    assign inc_vec[g] = do_inc && (ds_dest  == 5'(g));
    assign dec_vec[g] = do_dec && (ws_waddr == 5'(g));
    sb_cnt_cell #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (sb_clear),
      .inc   (inc_vec[g]),
      .dec   (dec_vec[g]),
      .cnt   (cnt[g])
    );
  end

  // Hazard detect uses registered counters only: a write retiring this
  // cycle reaches the regfile at the edge, so its reader stalls one more
  // cycle.
  always_comb begin
    src_hit  = (ds_use_rj && ds_rj != 5'd0 && cnt[ds_rj] != '0) ||
               (ds_use_r2 && ds_r2 != 5'd0 && cnt[ds_r2] != '0);
    track    = ds_gr_we && ds_dest != 5'd0;
    full     = track && (cnt[ds_dest] == CNT_SAT || tot_q == TOT_MAX);
    ready_go = !ds_valid || !(src_hit || full);
  end

  // Update rules: an illegal issue (decode not ready) and a retire of an
  // idle register each raise err and are dropped. A flush drops every
  // event of its cycle, including error detection.
  always_comb begin
    issue_bad = ds_issue && !ready_go;
    do_inc    = ds_issue && ready_go && track && !sb_clear;
    ret_req   = ws_we && ws_waddr != 5'd0;
    ret_under = ret_req && cnt[ws_waddr] == '0;
    do_dec    = ret_req && !ret_under && !sb_clear;

    err_d = err_q;
    if (!sb_clear && (issue_bad || ret_under)) err_d = 1'b1;

    tot_d = tot_q;
    if (sb_clear)             tot_d = '0;
    else if (do_inc && !do_dec) tot_d = tot_q + TOT_W'(1);
    else if (do_dec && !do_inc) tot_d = tot_q - TOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign ds_ready_go = ready_go;
  assign sb_inflight = tot_q;
  assign sb_err      = err_q;

`ifdef SB_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] full_cycles_q,  full_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    full_cycles_d  = full_cycles_q;
    if (ds_valid && !ready_go && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    // full already implies !ready_go when ds_valid is high.
    if (ds_valid && full && full_cycles_q != 32'hFFFF_FFFF)
      full_cycles_d = full_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      full_cycles_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      full_cycles_q  <= full_cycles_d;
    end
  end

  assign sb_stall_cycles = stall_cycles_q;
  assign sb_full_cycles  = full_cycles_q;
`endif
endmodule
